// File: rtl/mips_ctrl_fsm_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller: decode inputs, ALU flags,
// memory handshake, datapath enables/selects and the retired-instruction count.
interface mips_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             ZF;
    logic             OF;
    logic             mem_ready;
    logic             PC_Write;
    logic [1:0]       PC_s;
    logic             IR_Write;
    logic             Mem_Req;
    logic             Mem_Write;
    logic             Reg_Write;
    logic [1:0]       w_r_s;
    logic [1:0]       wr_data_s;
    logic             rt_imm_s;
    logic             imm_sign;
    logic [2:0]       ALU_OP;
    logic             illegal;
    logic             ovf;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, ZF, OF, mem_ready,
        output PC_Write, PC_s, IR_Write, Mem_Req, Mem_Write, Reg_Write, w_r_s, wr_data_s,
               rt_imm_s, imm_sign, ALU_OP, illegal, ovf, instr_cnt
    );

    modport slave (
        output opcode, funct, ZF, OF, mem_ready,
        input  PC_Write, PC_s, IR_Write, Mem_Req, Mem_Write, Reg_Write, w_r_s, wr_data_s,
               rt_imm_s, imm_sign, ALU_OP, illegal, ovf, instr_cnt
    );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control FSM for the R/I/J MIPS core: IF -> ID -> EXE -> MEM -> WB sequencing,
// datapath enables/selects, memory handshake and retired-instruction counter.
module mips_ctrl_fsm #(
    parameter int unsigned CNT_W    = 32,
    parameter bit          OVF_TRAP = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mips_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_e;
    typedef enum logic [3:0] {
        K_ALU_R, K_ALU_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL
    } kind_e;

    state_e           state_q, state_d;
    kind_e            kind;
    logic [2:0]       dec_alu;
    logic             dec_sgn;
    logic             ovf_op;
    logic             of_q;
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        kind    = K_ILL;
        dec_alu = 3'b000;
        dec_sgn = 1'b0;
        ovf_op  = 1'b0;
        case (bus.opcode)
            6'b000000: begin
                kind = K_ALU_R;
                case (bus.funct)
                    6'b100000: begin dec_alu = 3'b100; ovf_op = 1'b1; end
                    6'b100010: begin dec_alu = 3'b101; ovf_op = 1'b1; end
                    6'b100100: dec_alu = 3'b000;
                    6'b100101: dec_alu = 3'b001;
                    6'b100110: dec_alu = 3'b010;
                    6'b100111: dec_alu = 3'b011;
                    6'b101011: dec_alu = 3'b110;
                    6'b000100: dec_alu = 3'b111;
                    default:   kind = K_ILL;
                endcase
            end
            6'b001000: begin kind = K_ALU_I; dec_alu = 3'b100; dec_sgn = 1'b1; ovf_op = 1'b1; end
            6'b001100: begin kind = K_ALU_I; dec_alu = 3'b000; end
            6'b001101: begin kind = K_ALU_I; dec_alu = 3'b001; end
            6'b001110: begin kind = K_ALU_I; dec_alu = 3'b010; end
            6'b001011: begin kind = K_ALU_I; dec_alu = 3'b110; dec_sgn = 1'b1; end
            6'b100011: begin kind = K_LW;    dec_alu = 3'b100; dec_sgn = 1'b1; end
            6'b101011: begin kind = K_SW;    dec_alu = 3'b100; dec_sgn = 1'b1; end
            6'b000100: begin kind = K_BEQ;   dec_alu = 3'b101; end
            6'b000101: begin kind = K_BNE;   dec_alu = 3'b101; end
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        bus.PC_Write  = 1'b0;
        bus.PC_s      = 2'b00;
        bus.IR_Write  = 1'b0;
        bus.Mem_Req   = 1'b0;
        bus.Mem_Write = 1'b0;
        bus.Reg_Write = 1'b0;
        bus.w_r_s     = 2'b00;
        bus.wr_data_s = 2'b00;
        bus.rt_imm_s  = 1'b0;
        bus.imm_sign  = 1'b0;
        bus.ALU_OP    = 3'b000;
        bus.illegal   = 1'b0;
        bus.ovf       = 1'b0;
        unique case (state_q)
            S_IF: begin
                bus.Mem_Req = 1'b1;
                if (bus.mem_ready) begin
                    bus.IR_Write = 1'b1;
                    bus.PC_Write = 1'b1;
                    state_d      = S_ID;
                end
            end
            S_ID: begin
                case (kind)
                    K_J, K_JAL: begin
                        bus.PC_Write = 1'b1;
                        bus.PC_s     = 2'b10;
                        if (kind == K_JAL) begin
                            bus.Reg_Write = 1'b1;
                            bus.w_r_s     = 2'b10;
                            bus.wr_data_s = 2'b10;
                        end
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    K_ILL: begin
                        bus.illegal = 1'b1;
                        state_d     = S_IF;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                bus.ALU_OP   = dec_alu;
                bus.rt_imm_s = (kind == K_ALU_I) || (kind == K_LW) || (kind == K_SW);
                bus.imm_sign = dec_sgn;
                case (kind)
                    K_BEQ, K_BNE: begin
                        bus.PC_Write = (kind == K_BEQ) ? bus.ZF : ~bus.ZF;
                        bus.PC_s     = 2'b01;
                        retire       = 1'b1;
                        state_d      = S_IF;
                    end
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                bus.Mem_Req   = 1'b1;
                bus.Mem_Write = (kind == K_SW);
                if (bus.mem_ready) begin
                    retire  = (kind == K_SW);
                    state_d = (kind == K_SW) ? S_IF : S_WB;
                end
            end
            S_WB: begin
                bus.w_r_s     = (kind == K_ALU_R) ? 2'b00 : 2'b01;
                bus.wr_data_s = (kind == K_LW) ? 2'b01 : 2'b00;
                if (OVF_TRAP && ovf_op && of_q) bus.ovf = 1'b1;
                else                            bus.Reg_Write = 1'b1;
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Outputs are forced low for the whole reset interval, not just after the next edge.
        if (!rst_n) begin
            retire        = 1'b0;
            bus.PC_Write  = 1'b0;
            bus.PC_s      = 2'b00;
            bus.IR_Write  = 1'b0;
            bus.Mem_Req   = 1'b0;
            bus.Mem_Write = 1'b0;
            bus.Reg_Write = 1'b0;
            bus.w_r_s     = 2'b00;
            bus.wr_data_s = 2'b00;
            bus.rt_imm_s  = 1'b0;
            bus.imm_sign  = 1'b0;
            bus.ALU_OP    = 3'b000;
            bus.illegal   = 1'b0;
            bus.ovf       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            of_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXE) of_q <= bus.OF;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized + directed bench for mips_ctrl_fsm: per-cycle output vectors from a
// table-driven instruction model, plus retire-count scoreboard.
module tb_mips_ctrl_fsm;
    localparam bit OVF_TRAP = 1'b1;
    localparam int KR = 0, KI = 1, KLW = 2, KSW = 3, KBEQ = 4, KBNE = 5, KJ = 6, KJAL = 7,
                   KILL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    mips_ctrl_fsm_if #(.CNT_W(32)) b ();

    mips_ctrl_fsm #(.CNT_W(32), .OVF_TRAP(OVF_TRAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] outs();
        return {b.PC_Write, b.PC_s, b.IR_Write, b.Mem_Req, b.Mem_Write, b.Reg_Write, b.w_r_s,
                b.wr_data_s, b.rt_imm_s, b.imm_sign, b.ALU_OP, b.illegal, b.ovf};
    endfunction

    function automatic logic [17:0] mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic mreq, input logic mw, input logic rw,
                                       input logic [1:0] wrs, input logic [1:0] wds,
                                       input logic rti, input logic sgn, input logic [2:0] alu,
                                       input logic ill, input logic ov);
        return {pcw, pcs, irw, mreq, mw, rw, wrs, wds, rti, sgn, alu, ill, ov};
    endfunction

    // Instruction table: class, ALU op, immediate sign, overflow-trappable.
    function automatic void decode(input logic [5:0] op, input logic [5:0] fn, output int kind,
                                   output logic [2:0] alu, output logic sgn, output logic ovo);
        kind = KILL; alu = 3'b000; sgn = 1'b0; ovo = 1'b0;
        if (op == 6'd0) begin
            kind = KR;
            if      (fn == 6'b100000) begin alu = 3'b100; ovo = 1'b1; end
            else if (fn == 6'b100010) begin alu = 3'b101; ovo = 1'b1; end
            else if (fn == 6'b100100) alu = 3'b000;
            else if (fn == 6'b100101) alu = 3'b001;
            else if (fn == 6'b100110) alu = 3'b010;
            else if (fn == 6'b100111) alu = 3'b011;
            else if (fn == 6'b101011) alu = 3'b110;
            else if (fn == 6'b000100) alu = 3'b111;
            else kind = KILL;
        end
        else if (op == 6'b001000) begin kind = KI; alu = 3'b100; sgn = 1'b1; ovo = 1'b1; end
        else if (op == 6'b001100) begin kind = KI; alu = 3'b000; end
        else if (op == 6'b001101) begin kind = KI; alu = 3'b001; end
        else if (op == 6'b001110) begin kind = KI; alu = 3'b010; end
        else if (op == 6'b001011) begin kind = KI; alu = 3'b110; sgn = 1'b1; end
        else if (op == 6'b100011) kind = KLW;
        else if (op == 6'b101011) kind = KSW;
        else if (op == 6'b000100) kind = KBEQ;
        else if (op == 6'b000101) kind = KBNE;
        else if (op == 6'b000010) kind = KJ;
        else if (op == 6'b000011) kind = KJAL;
    endfunction

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic zf, input logic of, input int w_if, input int w_mem);
        logic [17:0] eq[$];
        logic        mq[$];
        int          kind;
        logic [2:0]  alu;
        logic        sgn, ovo, trap;
        decode(op, fn, kind, alu, sgn, ovo);
        for (int i = 0; i < w_if; i++) begin
            eq.push_back(mk(0, 2'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0)); mq.push_back(0);
        end
        eq.push_back(mk(1, 2'd0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0)); mq.push_back(1);
        if (kind == KJ)
            eq.push_back(mk(1, 2'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
        else if (kind == KJAL)
            eq.push_back(mk(1, 2'd2, 0, 0, 0, 1, 2'd2, 2'd2, 0, 0, 3'd0, 0, 0));
        else if (kind == KILL)
            eq.push_back(mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 1, 0));
        else
            eq.push_back(mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
        mq.push_back(1'($urandom));
        if (kind == KBEQ || kind == KBNE) begin
            eq.push_back(mk((kind == KBEQ) ? zf : !zf, 2'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0,
                            3'b101, 0, 0));
            mq.push_back(1'($urandom));
        end else if (kind == KLW || kind == KSW) begin
            eq.push_back(mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 3'b100, 0, 0));
            mq.push_back(1'($urandom));
            for (int i = 0; i <= w_mem; i++) begin
                eq.push_back(mk(0, 2'd0, 0, 1, kind == KSW, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0));
                mq.push_back(i == w_mem);
            end
            if (kind == KLW) begin
                eq.push_back(mk(0, 2'd0, 0, 0, 0, 1, 2'd1, 2'd1, 0, 0, 3'd0, 0, 0));
                mq.push_back(1'($urandom));
            end
        end else if (kind == KR || kind == KI) begin
            eq.push_back(mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, kind == KI, sgn, alu, 0, 0));
            mq.push_back(1'($urandom));
            trap = OVF_TRAP && ovo && of;
            eq.push_back(mk(0, 2'd0, 0, 0, 0, !trap, (kind == KR) ? 2'd0 : 2'd1, 2'd0, 0, 0,
                            3'd0, 0, trap));
            mq.push_back(1'($urandom));
        end
        if (kind != KILL) exp_cnt = exp_cnt + 32'd1;
        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clk);
            b.mem_ready = mq[i];
            // IR only holds the new instruction once the fetch completes.
            if (i <= w_if) begin
                b.opcode = 6'($urandom);
                b.funct  = 6'($urandom);
            end else begin
                b.opcode = op;
                b.funct  = fn;
            end
            b.ZF = zf;
            b.OF = of;
            #1;
            chk($sformatf("%s c%0d", name, i), 32'(outs()), 32'(eq[i]));
        end
        @(posedge clk);
        #1;
        chk({name, " cnt"}, b.instr_cnt, exp_cnt);
    endtask

    logic [5:0] r_op[19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                            6'h0c, 6'h0d, 6'h0e, 6'h0b, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h03,
                            6'h3f};
    logic [5:0] r_fn[19] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00};

    initial begin
        int k;
        b.opcode = 6'd0; b.funct = 6'd0; b.ZF = 1'b1; b.OF = 1'b1; b.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset outs", 32'(outs()), 32'd0);
        chk("reset cnt", b.instr_cnt, 32'd0);
        b.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("add", 6'h00, 6'h20, 0, 0, 0, 0);
        run_instr("beq_t", 6'h04, 6'h00, 1, 0, 0, 0);
        run_instr("beq_nt", 6'h04, 6'h00, 0, 0, 1, 0);
        run_instr("bne_t", 6'h05, 6'h00, 0, 0, 0, 0);
        run_instr("lw_w3", 6'h23, 6'h00, 0, 0, 0, 3);
        run_instr("addi_of", 6'h08, 6'h00, 0, 1, 0, 0);
        run_instr("sub_of", 6'h00, 6'h22, 0, 1, 0, 0);
        run_instr("sltiu_of", 6'h0b, 6'h00, 0, 1, 0, 0);
        run_instr("xor_of", 6'h00, 6'h26, 0, 1, 0, 0);
        run_instr("jal", 6'h03, 6'h00, 0, 0, 0, 0);
        run_instr("j", 6'h02, 6'h00, 0, 0, 2, 0);
        run_instr("ill_op", 6'h3f, 6'h00, 0, 0, 0, 0);
        run_instr("ill_fn", 6'h00, 6'h3f, 0, 0, 0, 0);
        run_instr("sw_w2", 6'h2b, 6'h00, 0, 0, 1, 2);
        run_instr("andi", 6'h0c, 6'h00, 1, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 18));
            run_instr($sformatf("rnd%0d", n), r_op[k], r_fn[k], 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Abort a store while it waits in MEM.
        @(negedge clk); b.mem_ready = 1'b1; b.opcode = 6'h2b; b.funct = 6'h00;
        @(negedge clk); b.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw mem pre-rst", 32'(outs()), 32'(mk(0, 2'd0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 3'd0,
                                                   0, 0)));
        #1;
        rst_n = 1'b0;
        #1;
        chk("sw rst outs", 32'(outs()), 32'd0);
        chk("sw rst cnt", b.instr_cnt, 32'd0);
        b.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst hold outs", 32'(outs()), 32'd0);
        @(negedge clk);
        b.mem_ready = 1'b0;
        rst_n = 1'b1;
        exp_cnt = 32'd0;
        #1;
        chk("restart if", 32'(outs()), 32'(mk(0, 2'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0, 0)));
        run_instr("post_rst_or", 6'h00, 6'h25, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
